// File: rtl/btn_debounce.sv
// btn_debounce: synchronises and debounces raw push-button levels against a
// millisecond timebase. It produces clean stable levels and one-cycle
// press/release events for the downstream game core.
//
// Ports:
//   clk             clock shared with the game core
//   rst             synchronous reset, active-high
//   ticks_per_milli clk cycles per millisecond, sampled live (0 or 1 => tick every cycle)
//   btn_raw         raw asynchronous button levels, 1 = pressed
//   btn_stable      debounced level per button
//   btn_press       one-cycle pulse when a 0->1 transition is accepted
//   btn_release     one-cycle pulse when a 1->0 transition is accepted
//   press_valid     encoded-press event (only with BTN_DEBOUNCE_ENCODE_EN)
//   press_idx       lowest pressing button index, held between events
//                   (only with BTN_DEBOUNCE_ENCODE_EN)
//
// Optional feature macro: BTN_DEBOUNCE_ENCODE_EN. When it is undefined,
// press_valid and press_idx are tied to 0.
module btn_debounce #(
  parameter int unsigned NUM_BTNS    = 4,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned TICKS_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TICKS_WIDTH-1:0] ticks_per_milli,
  input  logic [NUM_BTNS-1:0]    btn_raw,
  output logic [NUM_BTNS-1:0]    btn_stable,
  output logic [NUM_BTNS-1:0]    btn_press,
  output logic [NUM_BTNS-1:0]    btn_release,
  output logic                   press_valid,
  output logic [1:0]             press_idx
);

  localparam int unsigned CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  logic [NUM_BTNS-1:0]    sync1_q, sync2_q;
  logic [TICKS_WIDTH-1:0] pre_q, pre_d, tpm_last;
  logic                   tpm_small, ms_tick;
  logic [NUM_BTNS-1:0]    stable_q, stable_d;
  logic [NUM_BTNS-1:0]    press_q, press_d;
  logic [NUM_BTNS-1:0]    release_q, release_d;
  logic [CW-1:0]          cnt_q [NUM_BTNS];
  logic [CW-1:0]          cnt_d [NUM_BTNS];

  // Millisecond prescaler. The >= comparison makes a live shrink of
  // ticks_per_milli below the current count wrap to 0 without a tick.
  always_comb begin
    tpm_small = (ticks_per_milli <= TICKS_WIDTH'(1));
    tpm_last  = ticks_per_milli - TICKS_WIDTH'(1);
    ms_tick   = tpm_small || (pre_q == tpm_last);
    pre_d     = pre_q + TICKS_WIDTH'(1);
    if (tpm_small || (pre_q >= tpm_last)) begin
      pre_d = '0;
    end
  end

  // Per-button debounce. Any cycle where the synchronised level matches the
  // accepted level restarts the count. The event pulses are registered
  // alongside stable_q so that they coincide with the new level.
  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (ms_tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i]  = sync2_q[i];
          cnt_d[i]     = '0;
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pre_q     <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      pre_q     <= pre_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_stable  = stable_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BTN_DEBOUNCE_ENCODE_EN
  // Only the first four buttons fit the 2-bit index.
  localparam int unsigned ENC_N = (NUM_BTNS < 4) ? NUM_BTNS : 4;

  logic       pv_q, pv_d;
  logic [1:0] idx_q, idx_d;

  // Scan from high to low so the lowest pressing index is the one kept.
  always_comb begin
    pv_d  = 1'b0;
    idx_d = idx_q;
    for (int unsigned j = 0; j < ENC_N; j++) begin
      if (press_d[ENC_N-1-j]) begin
        pv_d  = 1'b1;
        idx_d = 2'(ENC_N - 1 - j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      pv_q  <= pv_d;
      idx_q <= idx_d;
    end
  end

  assign press_valid = pv_q;
  assign press_idx   = idx_q;
`else
  assign press_valid = 1'b0;
  assign press_idx   = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: two instances (DEBOUNCE_MS=3 and 10) on one clock,
// directed scenarios plus a randomized run against a behavioural model.
module tb_btn_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [15:0] tpm3 = 16'd4, tpm10 = 16'd50;
  logic [3:0]  raw3 = '0, raw10 = '0;
  logic [3:0]  st3, pr3, rl3, st10, pr10, rl10;
  logic        pv3, pv10;
  logic [1:0]  ix3, ix10;

  btn_debounce #(.NUM_BTNS(4), .DEBOUNCE_MS(3), .TICKS_WIDTH(16)) u_dut3 (
    .clk(clk), .rst(rst), .ticks_per_milli(tpm3), .btn_raw(raw3),
    .btn_stable(st3), .btn_press(pr3), .btn_release(rl3),
    .press_valid(pv3), .press_idx(ix3));

  btn_debounce #(.NUM_BTNS(4), .DEBOUNCE_MS(10), .TICKS_WIDTH(16)) u_dut10 (
    .clk(clk), .rst(rst), .ticks_per_milli(tpm10), .btn_raw(raw10),
    .btn_stable(st10), .btn_press(pr10), .btn_release(rl10),
    .press_valid(pv10), .press_idx(ix10));

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: a new level is accepted once it has been seen
  // (after a two-cycle delay) without interruption for DEBOUNCE_MS
  // millisecond ticks. Index 0 models u_dut3, index 1 models u_dut10.
  bit [3:0] m_s1 [2];
  bit [3:0] m_s2 [2];
  bit [3:0] m_stab [2];
  bit [3:0] m_press [2];
  bit [3:0] m_rel [2];
  int       m_run [2][4];
  int       m_phase [2];
  bit       m_pv [2];
  bit [1:0] m_idx [2];

  always @(posedge clk) begin : model
    int d, tpm;
    bit tick;
    bit [3:0] raw;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_s1[k] = '0; m_s2[k] = '0; m_stab[k] = '0;
        m_press[k] = '0; m_rel[k] = '0; m_phase[k] = 0;
        m_pv[k] = 1'b0; m_idx[k] = '0;
        for (int b = 0; b < 4; b++) m_run[k][b] = 0;
      end else begin
        d   = (k == 0) ? 3 : 10;
        tpm = (k == 0) ? int'(tpm3) : int'(tpm10);
        raw = (k == 0) ? raw3 : raw10;
        tick = (tpm <= 1) || (m_phase[k] == tpm - 1);
        m_phase[k] = ((tpm <= 1) || (m_phase[k] >= tpm - 1)) ? 0 : m_phase[k] + 1;
        m_press[k] = '0;
        m_rel[k]   = '0;
        for (int b = 0; b < 4; b++) begin
          if (m_s2[k][b] == m_stab[k][b]) m_run[k][b] = 0;
          else if (tick) begin
            m_run[k][b] = m_run[k][b] + 1;
            if (m_run[k][b] == d) begin
              m_stab[k][b] = ~m_stab[k][b];
              m_run[k][b]  = 0;
              if (m_stab[k][b]) m_press[k][b] = 1'b1;
              else              m_rel[k][b]   = 1'b1;
            end
          end
        end
        m_s2[k] = m_s1[k];
        m_s1[k] = raw;
`ifdef BTN_DEBOUNCE_ENCODE_EN
        if (m_press[k] != '0) begin
          m_pv[k] = 1'b1;
          for (int b = 3; b >= 0; b--) if (m_press[k][b]) m_idx[k] = 2'(b);
        end else begin
          m_pv[k] = 1'b0;
        end
`endif
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; raw3 = 4'b1111; raw10 = 4'b0101;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({st3, pr3, rl3, pv3, ix3} !== 15'd0) begin
      n_bad++; $display("FAIL reset_dut3: got %h expected 0", {st3, pr3, rl3, pv3, ix3});
    end
    n_cmp++;
    if ({st10, pr10, rl10, pv10, ix10} !== 15'd0) begin
      n_bad++; $display("FAIL reset_dut10: got %h expected 0", {st10, pr10, rl10, pv10, ix10});
    end
    raw3 = '0; raw10 = '0;
    rst = 1'b0;
  endtask

  task automatic test_press_latency();
    int n, npress;
    bit seen, coincident, rel_seen;
    tpm3 = 16'd4; raw3 = '0;
    apply_reset();
    repeat (5) @(negedge clk);
    raw3[0] = 1'b1;
    n = 0; npress = 0; seen = 0; coincident = 0; rel_seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (pr3[0]) npress++;
      if (rl3 != '0) rel_seen = 1;
      if (st3[0]) begin seen = 1; coincident = pr3[0]; end
    end
    repeat (4) begin
      @(negedge clk);
      if (pr3[0]) npress++;
      if (rl3 != '0) rel_seen = 1;
    end
    n_cmp++;
    if (!seen || n < 10 || n > 14) begin
      n_bad++; $display("FAIL press_latency: got %0d cycles (seen=%0d) expected 10..14", n, seen);
    end
    n_cmp++;
    if (coincident !== 1'b1) begin
      n_bad++; $display("FAIL press_coincident: got %0d expected 1", coincident);
    end
    n_cmp++;
    if (npress != 1) begin
      n_bad++; $display("FAIL press_count: got %0d expected 1", npress);
    end
    n_cmp++;
    if (rel_seen) begin
      n_bad++; $display("FAIL no_release: got 1 expected 0");
    end
  endtask

  task automatic test_bounce_reject();
    tpm3 = 16'd4; raw3 = '0;
    apply_reset();
    for (int c = 0; c < 56; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({st3[1], pr3[1], rl3[1]} !== 3'b000) begin
        n_bad++; $display("FAIL bounce_reject c=%0d: got %b expected 000", c, {st3[1], pr3[1], rl3[1]});
      end
      raw3[1] = (c < 50) && ((c % 10) < 8);
    end
  endtask

  task automatic test_fast_tick();
    int n;
    bit ok;
    tpm3 = 16'd0; raw3 = '0;
    apply_reset();
    repeat (3) @(negedge clk);
    raw3[2] = 1'b1;
    n = 0; ok = 0;
    while (!st3[2] && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (st3[2]) ok = pr3[2];
    end
    n_cmp++;
    if (n != 5 || !ok) begin
      n_bad++; $display("FAIL fast_rise: got %0d cycles press=%0d expected 5 cycles press=1", n, ok);
    end
    repeat (3) @(negedge clk);
    raw3[2] = 1'b0;
    n = 0; ok = 0;
    while (!rl3[2] && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (rl3[2]) ok = !st3[2] && !pr3[2];
    end
    n_cmp++;
    if (n != 5 || !ok) begin
      n_bad++; $display("FAIL fast_release: got %0d cycles ok=%0d expected 5 cycles ok=1", n, ok);
    end
    @(negedge clk);
    n_cmp++;
    if (rl3[2] !== 1'b0) begin
      n_bad++; $display("FAIL release_width: got %b expected 0", rl3[2]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bit       exp_pv;
    bit [1:0] exp_idx;
`ifdef BTN_DEBOUNCE_ENCODE_EN
    exp_pv = 1'b1; exp_idx = 2'd1;
`else
    exp_pv = 1'b0; exp_idx = 2'd0;
`endif
    tpm3 = 16'd0; raw3 = '0;
    apply_reset();
    repeat (3) @(negedge clk);
    raw3 = 4'b1010;
    n = 0;
    while (pr3 == '0 && n < 20) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    n_cmp++;
    if (pr3 !== 4'b1010 || st3 !== 4'b1010 || n != 5) begin
      n_bad++; $display("FAIL simul_press: got press=%b stable=%b n=%0d expected 1010 1010 5", pr3, st3, n);
    end
    n_cmp++;
    if (pv3 !== exp_pv || ix3 !== exp_idx) begin
      n_bad++; $display("FAIL encode_event: got pv=%b idx=%0d expected pv=%b idx=%0d", pv3, ix3, exp_pv, exp_idx);
    end
    @(negedge clk);
    n_cmp++;
    if (pr3 !== 4'b0000 || pv3 !== 1'b0 || ix3 !== exp_idx) begin
      n_bad++; $display("FAIL encode_hold: got press=%b pv=%b idx=%0d expected 0000 0 %0d", pr3, pv3, ix3, exp_idx);
    end
  endtask

  task automatic test_reset_mid_count();
    int n, npress;
    tpm3 = 16'd4; raw3 = '0;
    apply_reset();
    repeat (3) @(negedge clk);
    raw3[0] = 1'b1;
    n = 0;
    while (m_run[0][0] != 2 && n < 60) begin
      @(negedge clk); n++;
    end
    n_cmp++;
    if (m_run[0][0] != 2) begin
      n_bad++; $display("FAIL midcount_wait: got %0d expected 2", m_run[0][0]);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({st3, pr3, rl3, pv3, ix3} !== 15'd0) begin
      n_bad++; $display("FAIL midcount_rst: got %h expected 0", {st3, pr3, rl3, pv3, ix3});
    end
    rst = 1'b0;
    n = 0; npress = 0;
    while (!st3[0] && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (pr3[0]) npress++;
    end
    repeat (4) begin
      @(negedge clk);
      if (pr3[0]) npress++;
    end
    n_cmp++;
    if (n != 12) begin
      n_bad++; $display("FAIL midcount_latency: got %0d expected 12", n);
    end
    n_cmp++;
    if (npress != 1) begin
      n_bad++; $display("FAIL midcount_press: got %0d expected 1", npress);
    end
  endtask

  task automatic test_ms_rate();
    int n;
    int tpms [2];
    int lo [2];
    int hi [2];
    tpms[0] = 62; lo[0] = 558; hi[0] = 623;
    tpms[1] = 50; lo[1] = 450; hi[1] = 503;
    for (int r = 0; r < 2; r++) begin
      raw10 = '0; tpm10 = 16'(tpms[r]);
      apply_reset();
      repeat (3) @(negedge clk);
      raw10[0] = 1'b1;
      n = 0;
      while (!st10[0] && n < 800) begin
        @(posedge clk); n++;
        @(negedge clk);
      end
      n_cmp++;
      if (!st10[0] || n < lo[r] || n > hi[r]) begin
        n_bad++; $display("FAIL ms_rate_%0d: got %0d cycles expected %0d..%0d", tpms[r], n, lo[r], hi[r]);
      end
    end
    raw10 = '0;
  endtask

  task automatic test_random();
    logic [14:0] act, exp;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      act = {st3, pr3, rl3, pv3, ix3};
      exp = {m_stab[0], m_press[0], m_rel[0], m_pv[0], m_idx[0]};
      n_cmp++;
      if (act !== exp) begin
        n_bad++; $display("FAIL random_dut3 c=%0d: got %h expected %h", c, act, exp);
      end
      act = {st10, pr10, rl10, pv10, ix10};
      exp = {m_stab[1], m_press[1], m_rel[1], m_pv[1], m_idx[1]};
      n_cmp++;
      if (act !== exp) begin
        n_bad++; $display("FAIL random_dut10 c=%0d: got %h expected %h", c, act, exp);
      end
      rst = ($urandom_range(0, 399) == 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 29) == 0) raw3[b] = ~raw3[b];
        if ($urandom_range(0, 59) == 0) raw10[b] = ~raw10[b];
      end
      if ($urandom_range(0, 149) == 0) tpm3 = 16'($urandom_range(0, 6));
      if ($urandom_range(0, 149) == 0) tpm10 = 16'($urandom_range(0, 3));
    end
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_press_latency();
    test_bounce_reject();
    test_fast_tick();
    test_back_to_back();
    test_reset_mid_count();
    test_ms_rate();
    tpm3 = 16'd3; tpm10 = 16'd1;
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
